uart_rx_frontend: RTL and testbench
===================================

# uart_rx_frontend

Serial receive front end for the UART. Takes the raw RXD pin from the dedicated input bits, synchronises it, detects and validates start bits, and samples mid-bit with a fixed clock divisor. Each completed 8N1 frame is delivered as a byte over a valid/ready handshake to the UART core, which sits directly downstream. Framing errors and overruns are reported as single-cycle strobes.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit. Must be an even integer ≥ 4.
- DATA_BITS, 8: data bits per frame. Sent LSB first.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: **synchronous, active-high reset.**
- io_rxd, input, 1: raw asynchronous serial input. Idles high.
- io_rxReady, input, 1: downstream accepts the byte this cycle.
- io_rxValid, output, 1: holding register holds an unconsumed byte.
- io_rxData, output, DATA_BITS: received byte. Stable while io_rxValid=1.
- io_frameError, output, 1: one-cycle pulse when the stop bit is sampled low.
- io_overrun, output, 1: one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation
- **Synchroniser:** 2-flop synchroniser on io_rxd, both flops reset to 1. All logic below uses the synchronised value `rxs`.
- **Counter:** cnt, width clog2(CLKS_PER_BIT), decrements every cycle in the START, DATA and STOP states. A "tick" is a cycle with cnt==0.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: if rxs==0, go to START with cnt=CLKS_PER_BIT/2-1.
  - START on tick: if rxs==0, go to DATA with cnt=CLKS_PER_BIT-1 and bitIdx=0. Otherwise the start was false: go to IDLE.
  - DATA on tick: shift rxs into the shift register MSB end (right shift, LSB-first reception), bitIdx++, reload cnt=CLKS_PER_BIT-1. After bit DATA_BITS-1, go to STOP.
  - STOP on tick, rxs==1: deliver the byte (see below) and go to IDLE immediately. The next start edge can be detected from the following cycle.
  - STOP on tick, rxs==0: pulse io_frameError, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This covers line breaks.
- **Delivery, with A = io_rxValid && io_rxReady (consume):**
  - io_rxValid=0, or A in the same cycle: load io_rxData from the shift register and set io_rxValid=1.
  - io_rxValid=1 and no A: keep the old byte, drop the new one, pulse io_overrun.
- **Consume with no delivery:** A alone clears io_rxValid next cycle.
- **io_rxData:** changes only on load.
- io_frameError and io_overrun are never asserted in the same cycle.

## Timing
- **Reset values:** state=IDLE, sync flops=1, io_rxValid=0, io_rxData=0, io_frameError=0, io_overrun=0, cnt=0, bitIdx=0.
- **Reset mid-frame:** the frame is abandoned with no error strobe, and a held byte is lost.
- **Input latency:** an io_rxd edge appears in rxs 2 cycles later.
- **Frame schedule:** let t0 be the cycle with rxs first 0 in IDLE.
  - Start check at t0+CLKS_PER_BIT/2.
  - Data bit k sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at t0+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT.
- **Outputs after the stop sample (cycle s):**
  - io_rxValid/io_rxData update at the rising edge ending cycle s, and are visible from s+1.
  - Strobes are high for exactly cycle s+1.
- **Handshake:** the byte transfers in any cycle with io_rxValid && io_rxReady. io_rxValid may drop only after a transfer. io_rxReady may be held high permanently.
- **Throughput:** back-to-back frames with no idle gap are received without loss, provided the downstream consumes within one frame time.

## Test plan
- **Basic frame:** N=16, send 0x55 (start, 1,0,1,0,1,0,1,0, stop), io_rxReady=1 → io_rxValid high for 1 cycle with io_rxData=0x55, 1 cycle after the stop sample. No strobes.
- **False start:** drive io_rxd low for 3 cycles, then high → no io_rxValid and no strobes. The FSM is back in IDLE by t0+9, and a following 0xA3 frame is received correctly.
- **Framing error:** send 0x3C with the stop bit low, then hold low 40 cycles → io_frameError one pulse, io_rxValid stays 0. The FSM stays in WAIT_HIGH until the line is high. A following 0x81 is received.
- **Overrun:** send 0x11 then 0x22 back-to-back with io_rxReady=0 → io_rxData=0x11 is retained and io_overrun pulses once. Raising io_rxReady then transfers 0x11 and clears io_rxValid.
- **Consume on completion:** 0x11 is pending and io_rxReady=1 exactly in the 0x22 stop-sample cycle → no overrun, and io_rxData=0x22 with io_rxValid=1 next cycle.
- **Reset mid-frame:** assert reset during data bit 4 → all outputs 0 next cycle and the FSM is in IDLE. A following full 0xF0 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frontend
// Purpose  : 8N1 serial receiver with a fixed clock divisor, mid-bit sampling,
//            a one-byte valid/ready holding register and error strobes.
// Revision : 1.0
// ============================================================================
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_rxd,
  input  logic                 io_rxReady,
  output logic                 io_rxValid,
  output logic [DATA_BITS-1:0] io_rxData,
  output logic                 io_frameError,
  output logic                 io_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  logic                 sync1_q;
  logic                 sync2_q;
  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic w_rxs;
  logic w_tick;
  logic w_consume;

  assign w_rxs     = sync2_q;
  assign w_tick    = (cnt_q == '0);
  assign w_consume = valid_q && io_rxReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= io_rxd;
      sync2_q     <= sync1_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // A consume clears the holder; a delivery later in this block overrides it.
      if (w_consume) begin
        valid_q <= 1'b0;
      end

      if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
        cnt_q <= cnt_q - 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (!w_rxs) begin
            state_q <= S_START;
            cnt_q   <= HALF_LOAD;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_rxs) begin
              state_q   <= S_DATA;
              cnt_q     <= FULL_LOAD;
              bit_idx_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            shift_q   <= {w_rxs, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            cnt_q     <= FULL_LOAD;
            if (bit_idx_q == LAST_BIT) begin
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_rxs) begin
              state_q <= S_IDLE;
              if (!valid_q || w_consume) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (w_rxs) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign io_rxValid    = valid_q;
  assign io_rxData     = data_q;
  assign io_frameError = frame_err_q;
  assign io_overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frontend
// Purpose  : Directed self-checking bench for uart_rx_frontend (N=16, 8N1).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_frontend;

  localparam int N = 16;
  localparam logic [31:0] ST_IDLE      = 32'd0;
  localparam logic [31:0] ST_START     = 32'd1;
  localparam logic [31:0] ST_WAIT_HIGH = 32'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_rxd;
  logic       io_rxReady;
  logic       io_rxValid;
  logic [7:0] io_rxData;
  logic       io_frameError;
  logic       io_overrun;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] xfer_q[$];

  int fe0, ov0, vc0;

  uart_rx_frontend #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_rxd        (io_rxd),
    .io_rxReady    (io_rxReady),
    .io_rxValid    (io_rxValid),
    .io_rxData     (io_rxData),
    .io_frameError (io_frameError),
    .io_overrun    (io_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observes the DUT mid-cycle: handshake transfers, strobe pulses, valid rises.
  always @(negedge clk) begin
    if (io_rxValid === 1'b1) begin
      valid_cycles <= valid_cycles + 1;
      if (!prev_valid) rise_cyc <= cyc;
      if (io_rxReady === 1'b1) xfer_q.push_back(io_rxData);
    end
    prev_valid <= (io_rxValid === 1'b1);
    if (io_frameError === 1'b1) fe_cnt <= fe_cnt + 1;
    if (io_overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (io_frameError === 1'b1 && io_overrun === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    io_rxd = b;
    tick(N);
  endtask

  task automatic send_body(input logic [7:0] d);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_body(d);
    send_bit(stop);
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vc0 = valid_cycles;
  endtask

  task automatic expect_xfer(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    chk({tag, "_count"}, xfer_q.size(), 1);
    got = (xfer_q.size() > 0) ? xfer_q.pop_front() : 8'hxx;
    chk(tag, got, exp);
  endtask

  initial begin
    reset      = 1'b1;
    io_rxd     = 1'b1;
    io_rxReady = 1'b1;
    tick(3);
    chk("rst_valid", io_rxValid, 1'b0);
    chk("rst_data", io_rxData, 8'h00);
    chk("rst_fe", io_frameError, 1'b0);
    chk("rst_ov", io_overrun, 1'b0);
    chk("rst_state", dut.state_q, ST_IDLE);
    reset = 1'b0;
    tick(4);

    // Basic frame: valid rises 2 (sync) + 8 + 9*16 + 1 cycles after the start drive
    snap();
    send_frame(8'h55, 1'b1);
    tick(2);
    expect_xfer("basic_data", 8'h55);
    chk("basic_latency", rise_cyc - start_cyc, 155);
    chk("basic_valid_width", valid_cycles - vc0, 1);
    chk("basic_fe", fe_cnt - fe0, 0);
    chk("basic_ov", ov_cnt - ov0, 0);
    chk("basic_valid_after", io_rxValid, 1'b0);

    // False start: 3 low cycles, start check at t0+8 sees high, IDLE from t0+9
    snap();
    start_cyc = cyc;
    io_rxd = 1'b0;
    tick(3);
    io_rxd = 1'b1;
    tick(7);
    chk("false_state_t0p8", dut.state_q, ST_START);
    tick(1);
    chk("false_state_t0p9", dut.state_q, ST_IDLE);
    tick(8);
    chk("false_valid", valid_cycles - vc0, 0);
    chk("false_fe", fe_cnt - fe0, 0);
    chk("false_ov", ov_cnt - ov0, 0);
    send_frame(8'hA3, 1'b1);
    tick(2);
    expect_xfer("after_false_data", 8'hA3);

    // Framing error then a 40-cycle break
    snap();
    send_frame(8'h3C, 1'b0);
    tick(40);
    chk("ferr_pulses", fe_cnt - fe0, 1);
    chk("ferr_valid", valid_cycles - vc0, 0);
    chk("ferr_xfers", xfer_q.size(), 0);
    chk("ferr_state_wait", dut.state_q, ST_WAIT_HIGH);
    io_rxd = 1'b1;
    tick(4);
    chk("ferr_state_idle", dut.state_q, ST_IDLE);
    send_frame(8'h81, 1'b1);
    tick(2);
    expect_xfer("after_ferr_data", 8'h81);
    chk("after_ferr_ov", ov_cnt - ov0, 0);

    // Overrun: two back-to-back frames with nobody consuming
    snap();
    io_rxReady = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    chk("ovr_valid", io_rxValid, 1'b1);
    chk("ovr_data", io_rxData, 8'h11);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    chk("ovr_fe", fe_cnt - fe0, 0);
    chk("ovr_xfers", xfer_q.size(), 0);
    io_rxReady = 1'b1;
    tick(1);
    chk("ovr_valid_cleared", io_rxValid, 1'b0);
    expect_xfer("ovr_xfer_data", 8'h11);

    // Consume exactly in the stop-sample cycle of the second frame
    snap();
    io_rxReady = 1'b0;
    send_frame(8'h11, 1'b1);
    tick(2);
    chk("coc_first_valid", io_rxValid, 1'b1);
    send_body(8'h22);
    io_rxd = 1'b1;
    tick(10);
    io_rxReady = 1'b1;
    tick(1);
    io_rxReady = 1'b0;
    chk("coc_valid", io_rxValid, 1'b1);
    chk("coc_data", io_rxData, 8'h22);
    chk("coc_ov", ov_cnt - ov0, 0);
    expect_xfer("coc_xfer_first", 8'h11);
    tick(5);
    io_rxReady = 1'b1;
    tick(1);
    chk("coc_valid_cleared", io_rxValid, 1'b0);
    expect_xfer("coc_xfer_second", 8'h22);

    // Reset in the middle of data bit 4 with a byte held
    snap();
    io_rxReady = 1'b0;
    send_frame(8'h5A, 1'b1);
    tick(2);
    chk("mid_held_valid", io_rxValid, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    io_rxd = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_valid", io_rxValid, 1'b0);
    chk("mid_rst_data", io_rxData, 8'h00);
    chk("mid_rst_fe", io_frameError, 1'b0);
    chk("mid_rst_ov", io_overrun, 1'b0);
    chk("mid_rst_state", dut.state_q, ST_IDLE);
    reset = 1'b0;
    tick(2 * N);
    io_rxReady = 1'b1;
    send_frame(8'hF0, 1'b1);
    tick(2);
    expect_xfer("mid_after_data", 8'hF0);
    chk("mid_fe", fe_cnt - fe0, 0);
    chk("mid_ov", ov_cnt - ov0, 0);

    chk("no_both_strobes", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
